// File: rtl/count_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_pkg
// Description : Shared constants and state encoding for count_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package count_seq_pkg;

    localparam int LEN_W_DEFAULT = 4;
    localparam int CNT_W         = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        STEP  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/count_sequencer_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter owning the last-grant pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       en,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] grant
);

    // 1 = requester 1 was served last, so requester 0 wins the next tie
    logic r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (upd) begin
            r_last <= upd_id;
        end
    end

    always_comb begin
        grant    = 2'b00;
        grant[0] = en & valid0 & (~valid1 | r_last);
        grant[1] = en & valid1 & (~valid0 | ~r_last);
    end

endmodule
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : count_sequencer
// Description : Shares a 2-bit step counter between two requesters and checks
//               the counter value after each burst.
// Revision    : 1.0 - initial release
// ============================================================================
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req0_clr,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [LEN_W-1:0] req1_len,
    input  logic             req1_clr,
    output logic             req1_ready,
    output logic             cnt_x,
    output logic             cnt_clr,
    input  logic [CNT_W-1:0] cnt_z,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_id,
    output logic [CNT_W-1:0] done_z,
    output logic             done_err,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic [LEN_W-1:0] w_sel_len;
    logic             w_sel_clr;
    logic [LEN_W-1:0] r_rem;
    logic [CNT_W-1:0] r_exp;
    logic             r_id;
    logic             r_cnt_x;
    logic             r_cnt_clr;
    logic             r_done_id;
    logic [CNT_W-1:0] r_done_z;
    logic             r_done_err;
    logic             w_upd;

    assign w_upd = (r_state == DONE) && done_ready;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .en     (r_state == IDLE),
        .upd    (w_upd),
        .upd_id (r_id),
        .grant  (w_grant)
    );

    assign w_accept  = |w_grant;
    assign w_sel_len = w_grant[1] ? req1_len : req0_len;
    assign w_sel_clr = w_grant[1] ? req1_clr : req0_clr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_sel_clr)             w_next = CLEAR;
                    else if (w_sel_len != '0)  w_next = STEP;
                    else                       w_next = CHECK;
                end
            end
            CLEAR:   w_next = (r_rem != '0) ? STEP : CHECK;
            STEP:    w_next = (r_rem == LEN_W'(1)) ? CHECK : STEP;
            CHECK:   w_next = DONE;
            DONE:    w_next = done_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt_x    <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_rem      <= '0;
            r_exp      <= '0;
            r_id       <= 1'b0;
            r_done_id  <= 1'b0;
            r_done_z   <= '0;
            r_done_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt_x   <= (w_next == STEP);
            r_cnt_clr <= (w_next == CLEAR);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_grant[1];
                        r_rem <= w_sel_len;
                        r_exp <= w_sel_clr ? '0 : cnt_z;
                    end
                end
                CLEAR: r_exp <= '0;
                STEP: begin
                    r_rem <= r_rem - LEN_W'(1);
                    r_exp <= r_exp + CNT_W'(1);
                end
                CHECK: begin
                    r_done_id  <= r_id;
                    r_done_z   <= cnt_z;
                    r_done_err <= (cnt_z != r_exp);
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign cnt_x      = r_cnt_x;
    assign cnt_clr    = r_cnt_clr;
    assign done_valid = (r_state == DONE);
    assign done_id    = r_done_id;
    assign done_z     = r_done_z;
    assign done_err   = r_done_err;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sequencer
// Description : Self-checking bench with a transaction-level timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sequencer;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_clr, req0_ready;
    logic [LW-1:0] req0_len;
    logic          req1_valid, req1_clr, req1_ready;
    logic [LW-1:0] req1_len;
    logic          cnt_x, cnt_clr;
    logic [1:0]    cnt_z;
    logic          done_valid, done_ready, done_id, done_err, busy;
    logic [1:0]    done_z;

    // environment counter with optional stuck-at override
    logic [1:0] ctr;
    logic       pl_en;
    logic [1:0] pl_val;
    logic       stuck;
    logic [1:0] stuck_val;
    assign cnt_z = stuck ? stuck_val : ctr;

    int n_checks = 0;
    int n_errors = 0;

    count_sequencer #(.LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_len(req0_len), .req0_clr(req0_clr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_len(req1_len), .req1_clr(req1_clr), .req1_ready(req1_ready),
        .cnt_x(cnt_x), .cnt_clr(cnt_clr), .cnt_z(cnt_z),
        .done_valid(done_valid), .done_ready(done_ready), .done_id(done_id),
        .done_z(done_z), .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en)        ctr <= pl_val;
        else if (cnt_clr) ctr <= 2'd0;
        else if (cnt_x)   ctr <= ctr + 2'd1;
    end

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Transaction model: a burst accepted in cycle 0 clears in cycle 1 (if clr),
    // steps for len cycles, checks in cycle clr+len+1, then offers done.
    bit m_busy = 0, m_last = 1, m_clr = 0, m_id = 0;
    int m_len = 0, m_p = 0, m_exp = 0, m_dz = 0, m_derr = 0;

    always @(negedge clk) begin
        bit e_r0, e_r1;
        int chkp;
        chk("one_ready", int'(req0_ready & req1_ready), 0);
        if (!rst_n) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_cnt_x", cnt_x, 0);
            chk("rst_cnt_clr", cnt_clr, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done_valid", done_valid, 0);
            chk("rst_done_fields", {done_id, done_z, done_err}, 0);
            m_busy = 0;
            m_last = 1;
        end else if (!m_busy) begin
            e_r0 = req0_valid && (!req1_valid || m_last);
            e_r1 = req1_valid && (!req0_valid || !m_last);
            chk("ready0", req0_ready, e_r0);
            chk("ready1", req1_ready, e_r1);
            chk("idle_cnt_x", cnt_x, 0);
            chk("idle_cnt_clr", cnt_clr, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done_valid", done_valid, 0);
            if (e_r0 || e_r1) begin
                m_id   = e_r1;
                m_clr  = e_r1 ? req1_clr : req0_clr;
                m_len  = e_r1 ? int'(req1_len) : int'(req0_len);
                m_exp  = ((m_clr ? 0 : int'(cnt_z)) + m_len) % 4;
                m_busy = 1;
                m_p    = 0;
            end
        end else begin
            m_p++;
            chkp = int'(m_clr) + m_len + 1;
            chk("busy_ready0", req0_ready, 0);
            chk("busy_ready1", req1_ready, 0);
            chk("busy", busy, 1);
            chk("cnt_clr", cnt_clr, int'(m_clr && m_p == 1));
            chk("cnt_x", cnt_x, int'(m_p >= 1 + int'(m_clr) && m_p <= int'(m_clr) + m_len));
            chk("done_valid", done_valid, int'(m_p > chkp));
            if (m_p == chkp) begin
                m_dz   = int'(cnt_z);
                m_derr = int'(int'(cnt_z) != m_exp);
            end
            if (m_p > chkp) begin
                chk("done_id", done_id, m_id);
                chk("done_z", done_z, m_dz);
                chk("done_err", done_err, m_derr);
                if (done_ready) begin
                    m_last = m_id;
                    m_busy = 0;
                end
            end
        end
    end

    task automatic set_req(input int id, input bit v, input int len, input bit clr);
        if (id == 0) begin
            req0_valid = v; req0_len = LW'(len); req0_clr = clr;
        end else begin
            req1_valid = v; req1_len = LW'(len); req1_clr = clr;
        end
    endtask

    task automatic preload(input int v);
        pl_en = 1; pl_val = 2'(v);
        @(posedge clk); #1;
        pl_en = 0;
    endtask

    // One request through to handshake; called just after a posedge.
    task automatic do_req(input int id, input int len, input bit clr, input int hold, input bit poke,
                          output int ncl, output int nx, output int lat,
                          output int did, output int dz, output int derr, output int nrdy);
        bit ok;
        ncl = 0; nx = 0; lat = -1; did = -1; dz = -1; derr = -1; nrdy = 0;
        set_req(id, 1, len, clr);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        set_req(id, 0, 0, 0);
        if (!ok) begin chk("accept_timeout", 0, 1); return; end
        ok = 0;
        for (int p = 1; p < 40; p++) begin
            @(negedge clk);
            ncl += int'(cnt_clr);
            nx  += int'(cnt_x);
            if (done_valid) begin
                lat = p; did = done_id; dz = done_z; derr = done_err; ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin chk("done_timeout", 0, 1); return; end
        @(posedge clk); #1;
        if (poke) set_req(1 - id, 1, 0, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            nrdy += int'(req0_ready | req1_ready);
            chk("hold_valid", done_valid, 1);
            chk("hold_z", done_z, dz);
            chk("hold_err", done_err, derr);
            @(posedge clk); #1;
        end
        done_ready = 1;
        if (poke) set_req(1 - id, 0, 0, 0);
        @(posedge clk); #1;
        done_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ncl, nx, lat, did, dz, derr, nrdy, ng;
        int order [3];
        rst_n = 0; done_ready = 0; stuck = 0; stuck_val = 0;
        pl_en = 1; pl_val = 0;
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_busy", busy, 0);
        chk("init_done_valid", done_valid, 0);
        @(posedge clk); #1;
        rst_n = 1; pl_en = 0;

        // simple burst: counter at 2, clear then 3 steps
        preload(2);
        do_req(0, 3, 1, 0, 0, ncl, nx, lat, did, dz, derr, nrdy);
        chk("t1_nclr", ncl, 1);
        chk("t1_nx", nx, 3);
        chk("t1_latency", lat, 6);
        chk("t1_id", did, 0);
        chk("t1_z", dz, 3);
        chk("t1_err", derr, 0);

        // wrap without clear: 3 + 5 = 0 mod 4
        preload(3);
        do_req(1, 5, 0, 0, 0, ncl, nx, lat, did, dz, derr, nrdy);
        chk("t2_nx", nx, 5);
        chk("t2_latency", lat, 7);
        chk("t2_id", did, 1);
        chk("t2_z", dz, 0);
        chk("t2_err", derr, 0);

        // tie arbitration with both requesters held
        set_req(0, 1, 1, 0); set_req(1, 1, 1, 0);
        done_ready = 1; ng = 0;
        for (int i = 0; i < 60 && ng < 3; i++) begin
            @(negedge clk);
            if (req0_ready) begin order[ng] = 0; ng++; end
            else if (req1_ready) begin order[ng] = 1; ng++; end
        end
        @(posedge clk); #1;
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        chk("t3_ngrants", ng, 3);
        chk("t3_g0", order[0], 0);
        chk("t3_g1", order[1], 1);
        chk("t3_g2", order[2], 0);
        repeat (6) @(posedge clk); #1;
        done_ready = 0;

        // mismatch: counter output stuck at 1
        stuck = 1; stuck_val = 1;
        do_req(0, 2, 1, 0, 0, ncl, nx, lat, did, dz, derr, nrdy);
        stuck = 0;
        chk("t4_z", dz, 1);
        chk("t4_err", derr, 1);

        // len=0 no clear with backpressure; real counter is at 2
        do_req(1, 0, 0, 4, 1, ncl, nx, lat, did, dz, derr, nrdy);
        chk("t5_latency", lat, 2);
        chk("t5_nx", nx, 0);
        chk("t5_z", dz, 2);
        chk("t5_err", derr, 0);
        chk("t5_no_ready_in_hold", nrdy, 0);
        repeat (3) @(posedge clk); #1;

        // asynchronous reset during second step cycle
        set_req(0, 1, 3, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        @(posedge clk); #1;
        set_req(0, 0, 0, 0);
        @(posedge clk); #1;
        chk("t6_cnt_x_before", cnt_x, 1);
        #1 rst_n = 0;
        #1;
        chk("t6_cnt_x", cnt_x, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done_valid", done_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        set_req(0, 1, 0, 0); set_req(1, 1, 0, 0);
        @(negedge clk);
        chk("t6_tie_r0", req0_ready, 1);
        chk("t6_tie_r1", req1_ready, 0);
        @(posedge clk); #1;
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        done_ready = 1;
        repeat (4) @(posedge clk); #1;

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            set_req(0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
            set_req(1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
            done_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                stuck = ~stuck; stuck_val = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 399) == 0) begin
                set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
                #2 rst_n = 0;
                @(posedge clk); #1;
                rst_n = 1;
            end
            @(posedge clk); #1;
        end

        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        stuck = 0; done_ready = 1;
        repeat (30) @(posedge clk);
        chk("drain_idle", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
